// File: rtl/mmm_pkg.sv
// Shared types for the MMM output path: skid-buffer occupancy and the tagged beat.
// Beat data is sized for the widest supported output word; users fill the low ODW bits.
package mmm_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam int BEAT_MAX_DW = 64;

  typedef struct packed {
    logic [BEAT_MAX_DW-1:0] data;
    logic                   eor;   // last word of a row
    logic                   eom;   // last word of the matrix
    logic                   sat;   // word was clamped
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/axis_skid2.sv
// Two-entry skid buffer with registered in_ready and registered output beat.
// Handshake: a beat moves only when valid and ready are both high at a rising clk edge.
module axis_skid2
  import mmm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output occ_t         occ
);

  logic [W-1:0] spare_q;
  logic         ready_q;
  logic         acc;
  logic         xfer;

  // ready_q resets high so the port rises as soon as reset is released.
  assign in_ready = ready_q & ~rst;
  assign acc      = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ       <= OCC_EMPTY;
      out_data  <= '0;
      spare_q   <= '0;
      out_valid <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (acc) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            occ       <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (acc && !xfer) begin
            spare_q <= in_data;
            ready_q <= 1'b0;
            occ     <= OCC_TWO;
          end else if (acc && xfer) begin
            out_data <= in_data;
          end else if (xfer) begin
            out_valid <= 1'b0;
            occ       <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (xfer) begin
            out_data <= spare_q;
            ready_q  <= 1'b1;
            occ      <= OCC_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          ready_q   <= 1'b1;
          occ       <= OCC_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/mmm_out_framer.sv
// Frames the row-major MMM result stream: tags row/matrix ends, narrows to ODW, buffers 2 deep.
// Optional clamp-to-ODW saturation is enabled by defining MMM_OUT_SAT_EN.
module mmm_out_framer
  import mmm_pkg::*;
#(
  parameter int OUTW = 32,
  parameter int ODW  = 16,
  parameter int M    = 7,
  parameter int N    = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OUTW-1:0] IN_TDATA,
  input  logic            IN_TVALID,
  output logic            IN_TREADY,
  output logic [ODW-1:0]  OUT_TDATA,
  output logic            OUT_TVALID,
  input  logic            OUT_TREADY,
  output logic [1:0]      OUT_TUSER,
  output logic            OUT_TLAST,
  output logic            FRAME_DONE,
  output occ_t            occ_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           accept;
  logic [ODW-1:0] shaped;
  logic           sat_flag;
  beat_t          beat_in;
  beat_t          beat_out;

  assign accept = IN_TVALID & IN_TREADY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

`ifdef MMM_OUT_SAT_EN
  localparam logic signed [OUTW-1:0] SAT_MAX = {{(OUTW-ODW+1){1'b0}}, {(ODW-1){1'b1}}};
  localparam logic signed [OUTW-1:0] SAT_MIN = {{(OUTW-ODW+1){1'b1}}, {(ODW-1){1'b0}}};

  always_comb begin
    shaped   = IN_TDATA[ODW-1:0];
    sat_flag = 1'b0;
    if ($signed(IN_TDATA) > SAT_MAX) begin
      shaped   = SAT_MAX[ODW-1:0];
      sat_flag = 1'b1;
    end else if ($signed(IN_TDATA) < SAT_MIN) begin
      shaped   = SAT_MIN[ODW-1:0];
      sat_flag = 1'b1;
    end
  end
`else
  assign shaped   = IN_TDATA[ODW-1:0];
  assign sat_flag = 1'b0;

  // Plain truncation discards the high input bits.
  if (OUTW > ODW) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^IN_TDATA[OUTW-1:ODW];
  end
`endif

  // Tags come from the counters as they stand when the word is accepted.
  always_comb begin
    beat_in                = '0;
    beat_in.data[ODW-1:0]  = shaped;
    beat_in.eor            = (col == COL_LAST);
    beat_in.eom            = (col == COL_LAST) && (row == ROW_LAST);
    beat_in.sat            = sat_flag;
  end

  axis_skid2 #(
    .W(BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rst       (reset),
    .in_data   (beat_in),
    .in_valid  (IN_TVALID),
    .in_ready  (IN_TREADY),
    .out_data  (beat_out),
    .out_valid (OUT_TVALID),
    .out_ready (OUT_TREADY),
    .occ       (occ_state)
  );

  assign OUT_TDATA  = beat_out.data[ODW-1:0];
  assign OUT_TUSER  = {beat_out.sat, beat_out.eor};
  assign OUT_TLAST  = beat_out.eom;
  assign FRAME_DONE = OUT_TVALID & OUT_TREADY & beat_out.eom;

  if (ODW < BEAT_MAX_DW) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^beat_out.data[BEAT_MAX_DW-1:ODW];
  end

endmodule
